ysyx_22040759_mem_arb: RTL and testbench

Two-requester memory arbiter between the CPU's instruction-fetch port (icache side) and data-access port (dcache side), and the single request port of the AXI master bridge.
- Grants one requester at a time and keeps exactly one transaction outstanding downstream.
- Holds downstream request fields stable until the bridge answers, then steers the response back to the granted requester.
- Dcache has priority; a bounded starvation counter guarantees instruction-fetch progress.

---
 rtl/ysyx_22040759_mem_arb.sv | 131 +++++++++++++
 tb/tb_ysyx_22040759_mem_arb.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040759_mem_arb.sv
// Two-requester memory arbiter: icache fetch port and dcache data port share one
// AXI bridge request port, with dcache priority and a bounded icache starvation count.
module ysyx_22040759_mem_arb #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 64,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clock,
   input  logic              reset,

   input  logic              icache_valid_i,
   input  logic [ADDR_W-1:0] icache_addr_i,
   output logic              icache_ready_o,
   output logic [DATA_W-1:0] icache_data_o,

   input  logic              dcache_valid_i,
   input  logic              dcache_req_i,
   input  logic [ADDR_W-1:0] dcache_addr_i,
   input  logic [2:0]        dcache_size_i,
   input  logic [DATA_W-1:0] dcache_wdata_i,
   output logic              dcache_ready_o,
   output logic [DATA_W-1:0] dcache_rdata_o,

   output logic              mem_addr_valid_o,
   output logic              mem_wen_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [2:0]        mem_size_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_data_valid_i,
   input  logic [DATA_W-1:0] mem_rdata_i,

   output logic [1:0]        grant_o
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY_I,
      BUSY_D,
      RESP
   } state_t;

   localparam logic [1:0] GNT_NONE   = 2'b00;
   localparam logic [1:0] GNT_I      = 2'b01;
   localparam logic [1:0] GNT_D      = 2'b10;
   localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);
   localparam logic [2:0] FETCH_SIZE = 3'b011;

   state_t     state;
   logic [3:0] starve_cnt;
   logic [3:0] starve_inc;
   logic       pick_d;
   logic       pick_i;

   // Dcache wins unless a waiting icache has already lost LIMIT times in a row.
   always_comb begin
      pick_d     = 1'b0;
      pick_i     = 1'b0;
      starve_inc = starve_cnt;
      pick_d     = dcache_valid_i && !(icache_valid_i && (starve_cnt == LIMIT));
      pick_i     = !pick_d && icache_valid_i;
      starve_inc = (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 4'd1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         starve_cnt       <= 4'd0;
         mem_addr_valid_o <= 1'b0;
         mem_wen_o        <= 1'b0;
         mem_addr_o       <= '0;
         mem_size_o       <= 3'b000;
         mem_wdata_o      <= '0;
         icache_ready_o   <= 1'b0;
         dcache_ready_o   <= 1'b0;
         icache_data_o    <= '0;
         dcache_rdata_o   <= '0;
         grant_o          <= GNT_NONE;
      end else begin
         case (state)
            IDLE: begin
               if (pick_d) begin
                  state            <= BUSY_D;
                  grant_o          <= GNT_D;
                  mem_addr_valid_o <= 1'b1;
                  mem_wen_o        <= dcache_req_i;
                  mem_addr_o       <= dcache_addr_i;
                  mem_size_o       <= dcache_size_i;
                  mem_wdata_o      <= dcache_wdata_i;
                  starve_cnt       <= icache_valid_i ? starve_inc : 4'd0;
               end else if (pick_i) begin
                  state            <= BUSY_I;
                  grant_o          <= GNT_I;
                  mem_addr_valid_o <= 1'b1;
                  mem_wen_o        <= 1'b0;
                  mem_addr_o       <= icache_addr_i;
                  mem_size_o       <= FETCH_SIZE;
                  mem_wdata_o      <= '0;
                  starve_cnt       <= 4'd0;
               end
            end
            // Request fields stay frozen until the bridge completes; the response goes to the owner.
            BUSY_I: begin
               if (mem_data_valid_i) begin
                  state            <= RESP;
                  mem_addr_valid_o <= 1'b0;
                  icache_data_o    <= mem_rdata_i;
                  icache_ready_o   <= 1'b1;
               end
            end
            BUSY_D: begin
               if (mem_data_valid_i) begin
                  state            <= RESP;
                  mem_addr_valid_o <= 1'b0;
                  dcache_rdata_o   <= mem_rdata_i;
                  dcache_ready_o   <= 1'b1;
               end
            end
            RESP: begin
               state          <= IDLE;
               icache_ready_o <= 1'b0;
               dcache_ready_o <= 1'b0;
               grant_o        <= GNT_NONE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22040759_mem_arb.sv
// Scoreboard bench for ysyx_22040759_mem_arb: expected transactions are queued as
// requests are driven and popped when a ready pulse comes back.
module tb_ysyx_22040759_mem_arb;

   localparam int ADDR_W       = 32;
   localparam int DATA_W       = 64;
   localparam int STARVE_LIMIT = 4;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              icache_valid_i;
   logic [ADDR_W-1:0] icache_addr_i;
   logic              icache_ready_o;
   logic [DATA_W-1:0] icache_data_o;
   logic              dcache_valid_i;
   logic              dcache_req_i;
   logic [ADDR_W-1:0] dcache_addr_i;
   logic [2:0]        dcache_size_i;
   logic [DATA_W-1:0] dcache_wdata_i;
   logic              dcache_ready_o;
   logic [DATA_W-1:0] dcache_rdata_o;
   logic              mem_addr_valid_o;
   logic              mem_wen_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [2:0]        mem_size_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic              mem_data_valid_i;
   logic [DATA_W-1:0] mem_rdata_i;
   logic [1:0]        grant_o;

   ysyx_22040759_mem_arb #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clock(clock),
      .reset(reset),
      .icache_valid_i(icache_valid_i),
      .icache_addr_i(icache_addr_i),
      .icache_ready_o(icache_ready_o),
      .icache_data_o(icache_data_o),
      .dcache_valid_i(dcache_valid_i),
      .dcache_req_i(dcache_req_i),
      .dcache_addr_i(dcache_addr_i),
      .dcache_size_i(dcache_size_i),
      .dcache_wdata_i(dcache_wdata_i),
      .dcache_ready_o(dcache_ready_o),
      .dcache_rdata_o(dcache_rdata_o),
      .mem_addr_valid_o(mem_addr_valid_o),
      .mem_wen_o(mem_wen_o),
      .mem_addr_o(mem_addr_o),
      .mem_size_o(mem_size_o),
      .mem_wdata_o(mem_wdata_o),
      .mem_data_valid_i(mem_data_valid_i),
      .mem_rdata_i(mem_rdata_i),
      .grant_o(grant_o)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [1:0]        owner;
      logic [ADDR_W-1:0] addr;
      logic              wen;
      logic [2:0]        size;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] rdata;
   } exp_t;

   typedef struct {
      bit                got;
      int                wait_cycles;
      logic [1:0]        gnt;
      logic [ADDR_W-1:0] addr;
      logic              wen;
      logic [2:0]        size;
      logic [DATA_W-1:0] wdata;
      bit                stable;
      logic              iready;
      logic              dready;
      logic [DATA_W-1:0] idata;
      logic [DATA_W-1:0] ddata;
      logic              valid_resp;
      logic [1:0]        gnt_resp;
      logic              iready2;
      logic              dready2;
      logic              valid2;
      logic [1:0]        gnt2;
   } obs_t;

   exp_t sb[$];
   int   checks = 0;
   int   fails  = 0;

   localparam logic [DATA_W-1:0] FETCH_DATA = 64'h0000_0013_0000_0093;
   localparam logic [DATA_W-1:0] WRITE_RESP = 64'h5A5A_5A5A_0000_0001;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Bridge model: waits (bounded) for a request, answers after 'latency' cycles,
   // and records what the arbiter showed around the response.
   task automatic applyStimulus(input int latency, input logic [DATA_W-1:0] rdata,
                                input bit drop_i, input bit raise_d, output obs_t o);
      o.got         = 1'b0;
      o.wait_cycles = 0;
      o.stable      = 1'b1;
      while (mem_addr_valid_o !== 1'b1 && o.wait_cycles < 20) begin
         tick();
         o.wait_cycles++;
      end
      if (mem_addr_valid_o !== 1'b1) return;
      o.got   = 1'b1;
      o.gnt   = grant_o;
      o.addr  = mem_addr_o;
      o.wen   = mem_wen_o;
      o.size  = mem_size_o;
      o.wdata = mem_wdata_o;
      if (drop_i)  icache_valid_i = 1'b0;
      if (raise_d) dcache_valid_i = 1'b1;
      for (int k = 0; k < latency; k++) begin
         tick();
         if ({mem_addr_valid_o, grant_o, mem_addr_o, mem_wen_o, mem_size_o, mem_wdata_o} !==
             {1'b1, o.gnt, o.addr, o.wen, o.size, o.wdata})
            o.stable = 1'b0;
      end
      mem_data_valid_i = 1'b1;
      mem_rdata_i      = rdata;
      tick();
      mem_data_valid_i = 1'b0;
      mem_rdata_i      = '0;
      o.iready     = icache_ready_o;
      o.dready     = dcache_ready_o;
      o.idata      = icache_data_o;
      o.ddata      = dcache_rdata_o;
      o.valid_resp = mem_addr_valid_o;
      o.gnt_resp   = grant_o;
      tick();
      o.iready2 = icache_ready_o;
      o.dready2 = dcache_ready_o;
      o.valid2  = mem_addr_valid_o;
      o.gnt2    = grant_o;
   endtask

   function automatic exp_t to_act(input obs_t o);
      exp_t a;
      a.owner = o.gnt;
      a.addr  = o.addr;
      a.wen   = o.wen;
      a.size  = o.size;
      a.wdata = o.wdata;
      a.rdata = (o.gnt == 2'b10) ? o.ddata : o.idata;
      return a;
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      tick();
      tick();
      checks++;
      if ({mem_addr_valid_o, mem_wen_o, mem_addr_o, mem_size_o, mem_wdata_o, icache_ready_o,
           dcache_ready_o, icache_data_o, dcache_rdata_o, grant_o} !== '0) begin
         fails++;
         $display("[TB] FAIL reset_outputs: got valid=%b grant=%b addr=%h, expected all zero",
                  mem_addr_valid_o, grant_o, mem_addr_o);
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_single_fetch();
      obs_t o;
      exp_t e;
      icache_addr_i  = 32'h8000_0000;
      icache_valid_i = 1'b1;
      sb.push_back('{owner: 2'b01, addr: 32'h8000_0000, wen: 1'b0, size: 3'b011, wdata: '0, rdata: FETCH_DATA});
      applyStimulus(3, FETCH_DATA, 1'b0, 1'b0, o);
      icache_valid_i = 1'b0;
      checks++;
      if (!o.got) begin fails++; $display("[TB] FAIL fetch_got: got no request, expected one"); end
      checks++;
      if (sb.size() == 0) begin fails++; $display("[TB] FAIL fetch_sb: got empty queue, expected entry"); end
      else begin
         e = sb.pop_front();
         if (to_act(o) !== e) begin fails++; $display("[TB] FAIL fetch_txn: got %h, expected %h", to_act(o), e); end
      end
      checks++;
      if (o.stable !== 1'b1) begin fails++; $display("[TB] FAIL fetch_stable: got %b, expected 1", o.stable); end
      checks++;
      if ({o.iready, o.dready, o.iready2, o.dready2} !== 4'b1000) begin
         fails++;
         $display("[TB] FAIL fetch_ready: got %b, expected 1000", {o.iready, o.dready, o.iready2, o.dready2});
      end
      checks++;
      if ({o.valid_resp, o.gnt_resp, o.gnt2} !== 5'b0_01_00) begin
         fails++;
         $display("[TB] FAIL fetch_resp_state: got %b, expected 00100", {o.valid_resp, o.gnt_resp, o.gnt2});
      end
   endtask

   task automatic test_dcache_write();
      obs_t o;
      exp_t e;
      dcache_req_i   = 1'b1;
      dcache_addr_i  = 32'h8000_1000;
      dcache_size_i  = 3'b010;
      dcache_wdata_i = 64'h0000_0000_DEAD_BEEF;
      dcache_valid_i = 1'b1;
      sb.push_back('{owner: 2'b10, addr: 32'h8000_1000, wen: 1'b1, size: 3'b010,
                     wdata: 64'h0000_0000_DEAD_BEEF, rdata: WRITE_RESP});
      applyStimulus(2, WRITE_RESP, 1'b0, 1'b0, o);
      dcache_valid_i = 1'b0;
      checks++;
      if (sb.size() == 0) begin fails++; $display("[TB] FAIL write_sb: got empty queue, expected entry"); end
      else begin
         e = sb.pop_front();
         if (to_act(o) !== e) begin fails++; $display("[TB] FAIL write_txn: got %h, expected %h", to_act(o), e); end
      end
      checks++;
      if (o.stable !== 1'b1 || o.gnt_resp !== 2'b10) begin
         fails++;
         $display("[TB] FAIL write_grant_stable: got stable=%b resp_grant=%b, expected 1 and 10", o.stable, o.gnt_resp);
      end
      checks++;
      if ({o.iready, o.dready, o.iready2, o.dready2} !== 4'b0100) begin
         fails++;
         $display("[TB] FAIL write_ready: got %b, expected 0100", {o.iready, o.dready, o.iready2, o.dready2});
      end
      checks++;
      if (o.idata !== FETCH_DATA) begin
         fails++;
         $display("[TB] FAIL write_idata_hold: got %h, expected %h", o.idata, FETCH_DATA);
      end
   endtask

   task automatic test_spurious();
      mem_rdata_i      = 64'hFFFF_FFFF_FFFF_FFFF;
      mem_data_valid_i = 1'b1;
      tick();
      mem_data_valid_i = 1'b0;
      mem_rdata_i      = '0;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if ({icache_ready_o, dcache_ready_o, mem_addr_valid_o, grant_o, icache_data_o, dcache_rdata_o} !==
             {3'b000, 2'b00, FETCH_DATA, WRITE_RESP}) begin
            fails++;
            $display("[TB] FAIL spurious_%0d: got rdy=%b%b v=%b g=%b id=%h dd=%h, expected idle/unchanged",
                     k, icache_ready_o, dcache_ready_o, mem_addr_valid_o, grant_o, icache_data_o, dcache_rdata_o);
         end
         tick();
      end
   endtask

   task automatic test_starvation();
      obs_t o;
      exp_t e;
      string order = "DDDDIDDDDI";
      logic [DATA_W-1:0] rd;
      icache_addr_i  = 32'h8000_2000;
      dcache_req_i   = 1'b0;
      dcache_addr_i  = 32'h8000_3000;
      dcache_size_i  = 3'b011;
      dcache_wdata_i = 64'h0000_0000_0000_1111;
      for (int k = 0; k < 10; k++) begin
         rd = 64'hC0DE_0000_0000_0000 | 64'(k);
         if (order[k] == "I")
            sb.push_back('{owner: 2'b01, addr: 32'h8000_2000, wen: 1'b0, size: 3'b011, wdata: '0, rdata: rd});
         else
            sb.push_back('{owner: 2'b10, addr: 32'h8000_3000, wen: 1'b0, size: 3'b011,
                           wdata: 64'h0000_0000_0000_1111, rdata: rd});
      end
      icache_valid_i = 1'b1;
      dcache_valid_i = 1'b1;
      for (int k = 0; k < 10; k++) begin
         rd = 64'hC0DE_0000_0000_0000 | 64'(k);
         applyStimulus(1 + (k % 3), rd, 1'b0, 1'b0, o);
         checks++;
         if (sb.size() == 0) begin fails++; $display("[TB] FAIL starve_sb_%0d: got empty queue, expected entry", k); end
         else begin
            e = sb.pop_front();
            if (to_act(o) !== e || {o.iready, o.dready} !== {e.owner[0], e.owner[1]}) begin
               fails++;
               $display("[TB] FAIL starve_txn_%0d: got %h rdy=%b%b, expected %h", k, to_act(o), o.iready, o.dready, e);
            end
         end
      end
      icache_valid_i = 1'b0;
      dcache_valid_i = 1'b0;
      tick();
   endtask

   task automatic test_drop_valid();
      obs_t o;
      exp_t e;
      icache_addr_i  = 32'h8000_4000;
      icache_valid_i = 1'b1;
      dcache_req_i   = 1'b0;
      dcache_addr_i  = 32'h8000_5000;
      dcache_size_i  = 3'b011;
      dcache_wdata_i = '0;
      sb.push_back('{owner: 2'b01, addr: 32'h8000_4000, wen: 1'b0, size: 3'b011, wdata: '0, rdata: 64'h1234});
      sb.push_back('{owner: 2'b10, addr: 32'h8000_5000, wen: 1'b0, size: 3'b011, wdata: '0, rdata: 64'h5678});
      applyStimulus(2, 64'h1234, 1'b1, 1'b1, o);
      checks++;
      e = sb.pop_front();
      if (to_act(o) !== e || {o.iready, o.iready2} !== 2'b10) begin
         fails++;
         $display("[TB] FAIL drop_txn: got %h rdy=%b%b, expected %h rdy=10", to_act(o), o.iready, o.iready2, e);
      end
      checks++;
      if ({o.valid_resp, o.valid2} !== 2'b00) begin
         fails++;
         $display("[TB] FAIL drop_gap: got %b, expected 00", {o.valid_resp, o.valid2});
      end
      applyStimulus(1, 64'h5678, 1'b0, 1'b0, o);
      dcache_valid_i = 1'b0;
      checks++;
      if (o.wait_cycles !== 1) begin
         fails++;
         $display("[TB] FAIL drop_next_latency: got %0d, expected 1", o.wait_cycles);
      end
      checks++;
      e = sb.pop_front();
      if (to_act(o) !== e || o.dready !== 1'b1) begin
         fails++;
         $display("[TB] FAIL drop_next_txn: got %h rdy=%b, expected %h rdy=1", to_act(o), o.dready, e);
      end
   endtask

   task automatic test_reset_mid();
      obs_t o;
      exp_t e;
      int   n = 0;
      dcache_req_i   = 1'b1;
      dcache_addr_i  = 32'h8000_6000;
      dcache_size_i  = 3'b011;
      dcache_wdata_i = 64'hAAAA;
      dcache_valid_i = 1'b1;
      while (mem_addr_valid_o !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if ({mem_addr_valid_o, mem_wen_o, mem_addr_o, mem_size_o, mem_wdata_o, icache_ready_o,
           dcache_ready_o, icache_data_o, dcache_rdata_o, grant_o} !== '0) begin
         fails++;
         $display("[TB] FAIL midreset_outputs: got valid=%b grant=%b addr=%h idata=%h, expected all zero",
                  mem_addr_valid_o, grant_o, mem_addr_o, icache_data_o);
      end
      dcache_valid_i = 1'b0;
      icache_addr_i  = 32'h8000_7000;
      icache_valid_i = 1'b1;
      tick();
      reset = 1'b1;
      sb.push_back('{owner: 2'b01, addr: 32'h8000_7000, wen: 1'b0, size: 3'b011, wdata: '0, rdata: 64'h9999});
      applyStimulus(1, 64'h9999, 1'b0, 1'b0, o);
      icache_valid_i = 1'b0;
      checks++;
      e = sb.pop_front();
      if (to_act(o) !== e || o.iready !== 1'b1) begin
         fails++;
         $display("[TB] FAIL midreset_fetch: got %h rdy=%b, expected %h rdy=1", to_act(o), o.iready, e);
      end
   endtask

   task automatic checkOutput();
      checks++;
      if (sb.size() != 0) begin
         fails++;
         $display("[TB] FAIL scoreboard_drain: got %0d left, expected 0", sb.size());
      end
   endtask

   initial begin
      icache_valid_i   = 1'b0;
      icache_addr_i    = '0;
      dcache_valid_i   = 1'b0;
      dcache_req_i     = 1'b0;
      dcache_addr_i    = '0;
      dcache_size_i    = 3'b000;
      dcache_wdata_i   = '0;
      mem_data_valid_i = 1'b0;
      mem_rdata_i      = '0;
      test_reset();
      test_single_fetch();
      test_dcache_write();
      test_spurious();
      test_starvation();
      test_drop_valid();
      test_reset_mid();
      checkOutput();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
